// File: rtl/apb_slave_ctrl.sv
// APB3 slave sequencer for the 64-bit timer register block: captures the setup
// phase, inserts WAIT_CYCLES wait states, and issues one-cycle wr_en/rd_en strobes.
module apb_slave_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [11:0] ADDR_MAX    = 12'h01C
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        wr_en,
  output logic        rd_en,
  output logic [11:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic        tim_pready,
  input  logic [31:0] reg_rdata,
  input  logic        reg_error,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        wr_q, wr_d;
  logic        ill_q, ill_d;

  logic setup, xfer;
  assign setup = psel & ~penable;
  assign xfer  = psel & penable;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    pready  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;

    case (state_q)
      S_IDLE: begin
        // psel&penable with no prior setup is a protocol violation and is ignored
        if (setup) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          strb_d  = pwrite ? pstrb : 4'h0;
          wr_d    = pwrite;
          ill_d   = (paddr[1:0] != 2'b00) | (paddr > ADDR_MAX);
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (!xfer)            state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_ACCESS;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        // Strobes are gated by xfer so an abort in ACCESS leaves the registers untouched
        pready  = xfer;
        wr_en   = xfer & wr_q & ~ill_q;
        rd_en   = xfer & ~wr_q & ~ill_q;
        prdata  = rd_en ? reg_rdata : 32'h0;
        pslverr = pready & (ill_q | (wr_en & reg_error));
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tim_pready = pready;
  assign busy       = (state_q != S_IDLE);
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign strb       = strb_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench: three instances with WAIT_CYCLES = 0, 3, 2 share the bus inputs;
// each test checks the instance whose wait setting it targets.
module tb_apb_slave_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] reg_rdata;
  logic        reg_error;

  logic [31:0] prdata [3];
  logic        pready [3], pslverr [3], wr_en [3], rd_en [3], tim_pready [3], busy [3];
  logic [11:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  strb [3];

  int checks = 0, failures = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_ctrl #(
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .ADDR_MAX   (12'h01C)
    ) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata[g]),
      .pready    (pready[g]),
      .pslverr   (pslverr[g]),
      .wr_en     (wr_en[g]),
      .rd_en     (rd_en[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .strb      (strb[g]),
      .tim_pready(tim_pready[g]),
      .reg_rdata (reg_rdata),
      .reg_error (reg_error),
      .busy      (busy[g])
    );
  end

  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_idle(input int n);
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  task automatic test_reset();
    sys_rst = 1; reg_rdata = '0; reg_error = 0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    next_cyc(); next_cyc();
    @(negedge sys_clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({prdata[d], pready[d], pslverr[d], wr_en[d], rd_en[d], tim_pready[d], busy[d],
           addr[d], wdata[d], strb[d]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: busy=%b pready=%b addr=%h wdata=%h strb=%h, required all 0",
                 d, busy[d], pready[d], addr[d], wdata[d], strb[d]);
      end
    end
    next_cyc();
    sys_rst = 0;
    next_cyc();
  endtask

  task automatic test_write_w0();
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h000; pwdata = 32'h0000_0103; pstrb = 4'h3;
    @(negedge sys_clk);
    checks++;
    if ({wr_en[0], pready[0], busy[0]} !== 3'b000) begin
      failures++;
      $display("FAIL w0_setup: wr_en=%b pready=%b busy=%b, required 000", wr_en[0], pready[0], busy[0]);
    end
    next_cyc();
    penable = 1;
    @(negedge sys_clk);
    checks++;
    if ({wr_en[0], pready[0], tim_pready[0], pslverr[0], busy[0]} !== 5'b11101) begin
      failures++;
      $display("FAIL w0_access_ctrl: wr_en=%b pready=%b tim_pready=%b pslverr=%b busy=%b, required 1 1 1 0 1",
               wr_en[0], pready[0], tim_pready[0], pslverr[0], busy[0]);
    end
    checks++;
    if (addr[0] !== 12'h000 || wdata[0] !== 32'h0000_0103 || strb[0] !== 4'h3) begin
      failures++;
      $display("FAIL w0_access_data: addr=%h wdata=%h strb=%h, required 000 00000103 3", addr[0], wdata[0], strb[0]);
    end
    next_cyc();
    psel = 0; penable = 0; pwdata = 32'hFFFF_FFFF;
    @(negedge sys_clk);
    checks++;
    if (wr_en[0] !== 1'b0 || busy[0] !== 1'b0 || wdata[0] !== 32'h0000_0103) begin
      failures++;
      $display("FAIL w0_after: wr_en=%b busy=%b wdata=%h, required 0 0 00000103", wr_en[0], busy[0], wdata[0]);
    end
    bus_idle(2);
  endtask

  task automatic test_read_w3();
    logic [33:0] exp_v;
    reg_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 6; c++) begin
      psel = (c <= 5); penable = (c >= 2 && c <= 5); pwrite = 0; paddr = 12'h004; pstrb = 4'hF;
      @(negedge sys_clk);
      exp_v = {(c == 5), (c == 5), (c == 5) ? 32'hDEAD_BEEF : 32'h0};
      checks++;
      if ({pready[1], rd_en[1], prdata[1]} !== exp_v || busy[1] !== (c >= 2 && c <= 5)) begin
        failures++;
        $display("FAIL w3_read_cycle%0d: pready=%b rd_en=%b prdata=%h busy=%b, required %b %b %h %b",
                 c, pready[1], rd_en[1], prdata[1], busy[1], exp_v[33], exp_v[32], exp_v[31:0], (c >= 2 && c <= 5));
      end
      if (c == 5) begin
        checks++;
        if (strb[1] !== 4'h0 || addr[1] !== 12'h004 || wr_en[1] !== 1'b0) begin
          failures++;
          $display("FAIL w3_read_latch: strb=%h addr=%h wr_en=%b, required 0 004 0", strb[1], addr[1], wr_en[1]);
        end
      end
      next_cyc();
    end
    reg_rdata = '0;
    bus_idle(2);
  endtask

  task automatic test_illegal();
    logic [11:0] a_tab [3] = '{12'h006, 12'h020, 12'h01C};
    logic        ill_tab [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      psel = 1; penable = 0; pwrite = 1; paddr = a_tab[i]; pwdata = 32'h1234_5678; pstrb = 4'hF;
      reg_rdata = 32'hA5A5_A5A5;
      @(negedge sys_clk);
      checks++;
      if (wr_en[0] !== 1'b0 || pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL illegal_setup_%h: wr_en=%b pready=%b, required 0 0", a_tab[i], wr_en[0], pready[0]);
      end
      next_cyc();
      penable = 1;
      @(negedge sys_clk);
      checks++;
      if (pready[0] !== 1'b1 || pslverr[0] !== ill_tab[i] || wr_en[0] !== ~ill_tab[i] ||
          rd_en[0] !== 1'b0 || prdata[0] !== 32'h0) begin
        failures++;
        $display("FAIL illegal_access_%h: pready=%b pslverr=%b wr_en=%b rd_en=%b prdata=%h, required 1 %b %b 0 0",
                 a_tab[i], pready[0], pslverr[0], wr_en[0], rd_en[0], prdata[0], ill_tab[i], ~ill_tab[i]);
      end
      next_cyc();
      bus_idle(2);
    end
    // Illegal read: must not strobe rd_en nor leak reg_rdata
    psel = 1; penable = 0; pwrite = 0; paddr = 12'h021;
    next_cyc();
    penable = 1;
    @(negedge sys_clk);
    checks++;
    if (pslverr[0] !== 1'b1 || rd_en[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL illegal_read: pslverr=%b rd_en=%b prdata=%h, required 1 0 0", pslverr[0], rd_en[0], prdata[0]);
    end
    next_cyc();
    reg_rdata = '0;
    bus_idle(2);
  endtask

  task automatic test_reg_error();
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h000; pwdata = 32'h0000_00FF; pstrb = 4'h1;
    next_cyc();
    penable = 1; reg_error = 1;
    @(negedge sys_clk);
    checks++;
    if ({pready[0], pslverr[0], wr_en[0]} !== 3'b111) begin
      failures++;
      $display("FAIL reg_error: pready=%b pslverr=%b wr_en=%b, required 1 1 1", pready[0], pslverr[0], wr_en[0]);
    end
    next_cyc();
    reg_error = 0;
    bus_idle(2);
  endtask

  task automatic test_violation();
    psel = 1; penable = 1; pwrite = 1; paddr = 12'h008; pwdata = 32'h5555_5555;
    next_cyc();
    psel = 0; penable = 0;
    @(negedge sys_clk);
    checks++;
    if (busy[0] !== 1'b0 || wr_en[0] !== 1'b0 || addr[0] === 12'h008) begin
      failures++;
      $display("FAIL idle_violation: busy=%b wr_en=%b addr=%h, required 0 0 and addr not 008", busy[0], wr_en[0], addr[0]);
    end
    bus_idle(2);
  endtask

  task automatic test_abort_w2();
    int strobes = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h004; pwdata = 32'hCAFE_0001; pstrb = 4'hF;
    next_cyc();
    psel = 0; penable = 0;
    @(negedge sys_clk);
    checks++;
    if (busy[2] !== 1'b1 || pready[2] !== 1'b0) begin
      failures++;
      $display("FAIL abort_wait: busy=%b pready=%b, required 1 0", busy[2], pready[2]);
    end
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      @(negedge sys_clk);
      if (c == 0) begin
        checks++;
        if (busy[2] !== 1'b0) begin
          failures++;
          $display("FAIL abort_idle: busy=%b, required 0", busy[2]);
        end
      end
      strobes += wr_en[2] + rd_en[2] + pready[2];
    end
    checks++;
    if (strobes !== 0) begin
      failures++;
      $display("FAIL abort_strobes: count=%0d, required 0", strobes);
    end
    next_cyc();
    bus_idle(1);
  endtask

  task automatic test_reset_mid_w2();
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'hBEEF_0002; pstrb = 4'hF;
    next_cyc();
    penable = 1; sys_rst = 1;
    next_cyc();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) sys_rst = 0;
      @(negedge sys_clk);
      checks++;
      if ({prdata[2], pready[2], pslverr[2], wr_en[2], rd_en[2], tim_pready[2], busy[2],
           addr[2], wdata[2], strb[2]} !== '0) begin
        failures++;
        $display("FAIL reset_mid_cycle%0d: busy=%b wr_en=%b pready=%b addr=%h wdata=%h strb=%h, required all 0",
                 c, busy[2], wr_en[2], pready[2], addr[2], wdata[2], strb[2]);
      end
      next_cyc();
    end
    bus_idle(2);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      psel = (c <= 4); penable = (c == 2 || c == 4); pwrite = 1; pstrb = 4'hF;
      paddr  = (c <= 2) ? 12'h00C : 12'h010;
      pwdata = (c <= 2) ? 32'h1111_000C : 32'h2222_0010;
      @(negedge sys_clk);
      pulses += wr_en[0];
      if (c == 2 || c == 4) begin
        checks++;
        if (wr_en[0] !== 1'b1 || addr[0] !== paddr || wdata[0] !== pwdata || pslverr[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_xfer_cycle%0d: wr_en=%b addr=%h wdata=%h pslverr=%b, required 1 %h %h 0",
                   c, wr_en[0], addr[0], wdata[0], pslverr[0], paddr, pwdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (wr_en[0] !== 1'b0 || busy[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_gap: wr_en=%b busy=%b, required 0 0", wr_en[0], busy[0]);
        end
      end
      next_cyc();
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL b2b_pulses: count=%0d, required 2", pulses);
    end
    bus_idle(2);
  endtask

  initial begin
    test_reset();
    test_write_w0();
    test_read_w3();
    test_illegal();
    test_reg_error();
    test_violation();
    test_abort_w2();
    test_reset_mid_w2();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
